uart_buffered: RTL and testbench
================================

Name: uart_buffered

Overview:
Parametrised successor to the unbuffered UART top. It holds a transmitter, a receiver and one synchronous FIFO per direction.
- Frame format is set by parameters: data width, parity mode and stop-bit count.
- Baud rate is a fixed clocks-per-bit divisor.
- Receive errors are reported through sticky status flags.
- The block sits between a host-side byte bus (wr/rd handshakes) and the serial pins.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 4 and even.
DATA_BITS, 8, payload bits per frame; legal range 5 to 9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; 1 or 2.
FIFO_DEPTH, 16, entries per FIFO; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
din  in  DATA_BITS  byte to transmit.
wr_en  in  1  pushes din into the TX FIFO when wr_rdy is 1.
wr_rdy  out  1  TX FIFO is not full.
rd_en  in  1  pops the RX FIFO head when rd_rdy is 1.
rd_rdy  out  1  RX FIFO is not empty.
dout  out  DATA_BITS  RX FIFO head (first-word fall-through); valid while rd_rdy is 1.
rx  in  1  serial input, asynchronous to clk.
tx  out  1  serial output; idle high.
err_clr  in  1  clears all sticky error flags.
parity_err  out  1  sticky: a received frame had a parity mismatch.
frame_err  out  1  sticky: a stop bit was sampled low.
overrun  out  1  sticky: a frame arrived while the RX FIFO was full.

Behaviour:
- Clocking and reset: one clock domain (clk). rst is synchronous and active-high. On the first clk edge with rst=1:
  - tx=1, wr_rdy=1, rd_rdy=0, dout=0;
  - all error flags 0;
  - both FIFOs empty;
  - both FSMs in IDLE and all counters 0.
- Reset mid-frame: the frame is aborted and tx returns to 1 on the same edge.
- Handshakes:
  - wr_en while wr_rdy=0 is ignored and FIFO contents are unchanged.
  - rd_en while rd_rdy=0 is ignored.
  - A simultaneous push and pop on the same FIFO is legal in every state, including full (when a pop frees the slot) and empty.
  - Occupancy is tracked with a pointer width of log2(FIFO_DEPTH)+1; wrap is the MSB toggle.
- Write latency: a push in cycle N makes wr_rdy reflect the new occupancy in cycle N+1.
- RX FIFO output: dout updates to the next entry the cycle after a pop.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the TX FIFO is not empty, pop the head into a shift register and go to START. tx falls 1 cycle after the pop.
  - Every bit is held for exactly CLKS_PER_BIT cycles.
  - Data is sent LSB first.
  - PARITY is skipped when PARITY=0. The parity bit is XOR of the data bits, inverted for odd mode.
  - STOP holds tx=1 for STOP_BITS × CLKS_PER_BIT cycles, then returns to IDLE.
  - Back-to-back frames: no idle gap beyond the 1-cycle pop latency.
- RX input conditioning: rx passes through a 2-flop synchronizer, reset to 1.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronized falling edge moves to START.
  - START: sample at CLKS_PER_BIT/2. If the sample is high, treat it as a glitch and return to IDLE with no flags set.
  - DATA and PARITY bits are sampled at mid-bit, every CLKS_PER_BIT cycles after that.
  - Only the first stop bit is checked; a second stop bit is not checked.
  - After the stop sample, the FSM returns to IDLE, so it can resync on the next start edge during the second half of the stop bit.
- RX commit at the stop sample:
  - Stop bit sampled 0: the byte is discarded and frame_err is set.
  - Parity mismatch: the byte is stored anyway and parity_err is set.
  - RX FIFO full: the byte is dropped and overrun is set; no write occurs even if a pop happens in the same cycle.
  - Error flags assert the cycle after the stop sample.
- Sticky flags: err_clr clears them. If err_clr coincides with a new error event, the flag stays set (set wins).

Decomposition:
- Package uart_pkg:
  - parity-mode constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2;
  - shared FSM state encoding IDLE/START/DATA/PARITY/STOP, 3 bits;
  - a clog2 helper function.
- Sub-module sync_fifo (WIDTH, DEPTH), first-word fall-through, instantiated twice.
- The TX and RX FSMs live in this module.
- Target size: about 250 lines.

Test Plan:
1. Serial TX framing: CLKS_PER_BIT=4, PARITY=2, push 0xA5 → tx idle 1, then 4 cycles each of start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1; wr_rdy stays 1.
2. Loopback burst: tx tied to rx, push 0x00,0xFF,0x3C,0x81 back-to-back → same 4 bytes read in order on dout; no error flags.
3. FIFO full, TX side: FIFO_DEPTH=4, push 5 bytes with the serial line stalled → wr_rdy=0 after the 4th FIFO entry; the 5th is ignored.
4. FIFO full, RX side: send 5 frames without rd_en, RX depth 4 → overrun=1; dout still returns the first 4 bytes; err_clr → overrun=0.
5. Error injection, parity: PARITY=1, drive a wrong parity bit → byte stored and parity_err=1.
6. Error injection, stop bit: stop bit forced 0 → byte discarded, frame_err=1, rd_rdy unchanged.
7. Glitch: 1-cycle low pulse on rx → no byte stored, no flags set.
8. Reset mid-frame: assert rst during TX DATA → tx=1 next edge, wr_rdy=1, rd_rdy=0, flags 0; the next push transmits a complete frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART: parity modes, FSM state encoding
// and a constant-evaluable ceil(log2) helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_buffered_fifo.sv
// First-word fall-through synchronous FIFO; occupancy uses one extra pointer
// bit so that full and empty are distinguished by the MSB toggle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_wr;
    logic             w_do_rd;

    assign empty   = (r_wptr == r_rptr);
    assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign w_do_wr = wr_en && (!full || w_do_rd);
    assign dout    = empty ? {WIDTH{1'b0}} : r_mem[r_rptr[AW-1:0]];

    // Read/write pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= {(AW+1){1'b0}};
            r_rptr <= {(AW+1){1'b0}};
        end else begin
            if (w_do_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_rd) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_buffered.sv
// Buffered UART: host byte bus <-> TX/RX FIFOs <-> serial FSMs, with sticky
// receive error flags and a fixed clocks-per-bit baud divisor.
module uart_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    output logic                 wr_rdy,
    input  logic                 rd_en,
    output logic                 rd_rdy,
    output logic [DATA_BITS-1:0] dout,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 err_clr,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = clog2(CLKS_PER_BIT);
    localparam int BW = clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic PAR_EN  = (PARITY != PARITY_NONE) && (PARITY <= PARITY_EVEN);
    localparam logic PAR_ODD = (PARITY == PARITY_ODD);

    logic                 w_tx_push;
    logic                 w_tx_pop;
    logic                 w_tx_full;
    logic                 w_tx_empty;
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_rx_push;
    logic                 w_rx_pop;
    logic                 w_rx_full;
    logic                 w_rx_empty;

    uart_state_t          r_tx_state, w_tx_state_nxt;
    logic [CW-1:0]        r_tx_cnt, w_tx_cnt_nxt;
    logic [BW-1:0]        r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                 r_tx_par, w_tx_par_nxt;
    logic                 r_tx, w_tx_line_nxt;

    uart_state_t          r_rx_state, w_rx_state_nxt;
    logic [CW-1:0]        r_rx_cnt, w_rx_cnt_nxt;
    logic [BW-1:0]        r_rx_bit, w_rx_bit_nxt;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                 r_rx_par, w_rx_par_nxt;
    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic                 w_rx_stop_smp;
    logic                 w_rx_par_bad;
    logic                 r_parity_err, r_frame_err, r_overrun;

    assign w_tx_push = wr_en && !w_tx_full;
    assign w_rx_pop  = rd_en && !w_rx_empty;
    assign wr_rdy    = !w_tx_full;
    assign rd_rdy    = !w_rx_empty;
    assign tx        = r_tx;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (w_tx_push),
        .din   (din),
        .rd_en (w_tx_pop),
        .dout  (w_tx_head),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (w_rx_push),
        .din   (r_rx_shift),
        .rd_en (w_rx_pop),
        .dout  (dout),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    // TX next-state logic; w_tx_line_nxt is the level tx takes on the next edge
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + CNT_ONE;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_tx_line_nxt  = r_tx;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt_nxt = CNT_ZERO;
                w_tx_bit_nxt = BIT_ZERO;
                if (!w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = w_tx_head;
                    w_tx_par_nxt   = (^w_tx_head) ^ PAR_ODD;
                    w_tx_state_nxt = ST_START;
                    w_tx_line_nxt  = 1'b0;
                end else begin
                    w_tx_line_nxt  = 1'b1;
                end
            end
            ST_START: begin
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nxt   = CNT_ZERO;
                    w_tx_state_nxt = ST_DATA;
                    w_tx_line_nxt  = r_tx_shift[0];
                end else begin
                    w_tx_line_nxt  = 1'b0;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nxt = CNT_ZERO;
                    if (r_tx_bit == BIT_LAST) begin
                        w_tx_bit_nxt = BIT_ZERO;
                        if (PAR_EN) begin
                            w_tx_state_nxt = ST_PARITY;
                            w_tx_line_nxt  = r_tx_par;
                        end else begin
                            w_tx_state_nxt = ST_STOP;
                            w_tx_line_nxt  = 1'b1;
                        end
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + BIT_ONE;
                        w_tx_shift_nxt = r_tx_shift >> 1;
                        w_tx_line_nxt  = r_tx_shift[1];
                    end
                end else begin
                    w_tx_line_nxt = r_tx_shift[0];
                end
            end
            ST_PARITY: begin
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nxt   = CNT_ZERO;
                    w_tx_state_nxt = ST_STOP;
                    w_tx_line_nxt  = 1'b1;
                end else begin
                    w_tx_line_nxt  = r_tx_par;
                end
            end
            ST_STOP: begin
                w_tx_line_nxt = 1'b1;
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nxt = CNT_ZERO;
                    // r_tx_bit counts stop bits here
                    if (r_tx_bit == STOP_LAST) begin
                        w_tx_bit_nxt   = BIT_ZERO;
                        w_tx_state_nxt = ST_IDLE;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + BIT_ONE;
                    end
                end else begin
                    w_tx_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_tx_state_nxt = ST_IDLE;
                w_tx_cnt_nxt   = CNT_ZERO;
                w_tx_line_nxt  = 1'b1;
            end
        endcase
    end

    // TX state and line registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= CNT_ZERO;
            r_tx_bit   <= BIT_ZERO;
            r_tx_shift <= {DATA_BITS{1'b0}};
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_tx       <= w_tx_line_nxt;
        end
    end

    // rx synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // RX next-state logic; all samples are taken at mid-bit
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + CNT_ONE;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_par_nxt   = r_rx_par;
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_cnt_nxt = CNT_ZERO;
                w_rx_bit_nxt = BIT_ZERO;
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_nxt = ST_START;
                end else begin
                    w_rx_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_rx_cnt == CNT_HALF) begin
                    w_rx_cnt_nxt   = CNT_ZERO;
                    w_rx_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    w_rx_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nxt   = CNT_ZERO;
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == BIT_LAST) begin
                        w_rx_bit_nxt   = BIT_ZERO;
                        w_rx_state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        w_rx_bit_nxt   = r_rx_bit + BIT_ONE;
                    end
                end else begin
                    w_rx_state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nxt   = CNT_ZERO;
                    w_rx_par_nxt   = r_rx_sync;
                    w_rx_state_nxt = ST_STOP;
                end else begin
                    w_rx_state_nxt = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nxt   = CNT_ZERO;
                    w_rx_state_nxt = ST_IDLE;
                end else begin
                    w_rx_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_rx_state_nxt = ST_IDLE;
                w_rx_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // RX state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= CNT_ZERO;
            r_rx_bit   <= BIT_ZERO;
            r_rx_shift <= {DATA_BITS{1'b0}};
            r_rx_par   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_par   <= w_rx_par_nxt;
        end
    end

    // Commit decision at the first stop-bit sample; a full FIFO drops the byte
    assign w_rx_stop_smp = (r_rx_state == ST_STOP) && (r_rx_cnt == CNT_LAST);
    assign w_rx_par_bad  = PAR_EN && (((^r_rx_shift) ^ PAR_ODD) != r_rx_par);
    assign w_rx_push     = w_rx_stop_smp && r_rx_sync && !w_rx_full;

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_parity_err <= (r_parity_err && !err_clr) || (w_rx_stop_smp && r_rx_sync && w_rx_par_bad);
            r_frame_err  <= (r_frame_err && !err_clr) || (w_rx_stop_smp && !r_rx_sync);
            r_overrun    <= (r_overrun && !err_clr) || (w_rx_stop_smp && r_rx_sync && w_rx_full);
        end
    end

endmodule

// File: tb/tb_uart_buffered.sv
// Directed bench for uart_buffered: 4 clocks/bit, 8 data bits, even parity,
// one stop bit, 4-entry FIFOs.
module tb_uart_buffered;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       wr_rdy, rd_rdy, tx, rx, parity_err, frame_err, overrun;
    logic [7:0] dout;

    int n_vec = 0;
    int n_err = 0;

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_buffered #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY       (2),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .wr_en      (wr_en),
        .wr_rdy     (wr_rdy),
        .rd_en      (rd_en),
        .rd_rdy     (rd_rdy),
        .dout       (dout),
        .rx         (rx),
        .tx         (tx),
        .err_clr    (err_clr),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; din = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Entered in the cycle right after the push edge; checks every serial cycle.
    task automatic check_frame(input logic [7:0] d, input string nm);
        logic [10:0] bits;
        bits = {1'b1, ^d, d, 1'b0};
        @(negedge clk);
        n_vec++;
        if (tx !== 1'b1) begin n_err++; $display("FAIL %s pre-start: tx=%b expected 1", nm, tx); end
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                n_vec++;
                if (tx !== bits[b]) begin
                    n_err++;
                    $display("FAIL %s bit%0d cyc%0d: tx=%b expected %b", nm, b, c, tx, bits[b]);
                end
                if (wr_rdy !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s wr_rdy during frame: got %b expected 1", nm, wr_rdy);
                end
            end
        end
        @(negedge clk);
        n_vec++;
        if (tx !== 1'b1) begin n_err++; $display("FAIL %s post-stop: tx=%b expected 1", nm, tx); end
    endtask

    task automatic read_byte(input logic [7:0] exp, input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (!rd_rdy && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (!rd_rdy) begin
            n_err++;
            $display("FAIL %s: timeout waiting for rd_rdy, expected byte %h", nm, exp);
        end else begin
            if (dout !== exp) begin
                n_err++;
                $display("FAIL %s: dout=%h expected %h", nm, dout, exp);
            end
            rd_en = 1'b1;
            @(posedge clk); #1;
            rd_en = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
        @(posedge clk); #1;
        for (int b = 0; b < 11; b++) begin
            rx_drv = bits[b];
            idle(CPB);
        end
        rx_drv = 1'b1;
        idle(CPB + 2);
    endtask

    task automatic check_flags(input logic pe, input logic fe, input logic ov, input string nm);
        @(negedge clk);
        n_vec++;
        if ({parity_err, frame_err, overrun} !== {pe, fe, ov}) begin
            n_err++;
            $display("FAIL %s flags pe/fe/ov: got %b%b%b expected %b%b%b",
                     nm, parity_err, frame_err, overrun, pe, fe, ov);
        end
    endtask

    task automatic check_rd_rdy(input logic exp, input string nm);
        @(negedge clk);
        n_vec++;
        if (rd_rdy !== exp) begin
            n_err++;
            $display("FAIL %s: rd_rdy=%b expected %b", nm, rd_rdy, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({tx, wr_rdy, rd_rdy, dout} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset outputs tx/wr_rdy/rd_rdy/dout: got %b%b%b/%h expected 110/00",
                     tx, wr_rdy, rd_rdy, dout);
        end
        check_flags(1'b0, 1'b0, 1'b0, "reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_tx_frame();
        push_one(8'hA5);
        check_frame(8'hA5, "tx_a5");
    endtask

    task automatic test_loopback();
        logic [7:0] vals [4];
        vals = '{8'h00, 8'hFF, 8'h3C, 8'h81};
        loop_en = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; din = vals[k];
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) read_byte(vals[k], "loopback");
        check_flags(1'b0, 1'b0, 1'b0, "loopback");
    endtask

    task automatic test_tx_full();
        logic [7:0] vals [6];
        logic       rdy_exp [6];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        // first byte leaves the FIFO for the shifter, so the 5th push fills it
        rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            wr_en = 1'b1; din = vals[k];
            @(negedge clk);
            n_vec++;
            if (wr_rdy !== rdy_exp[k]) begin
                n_err++;
                $display("FAIL tx_full push%0d: wr_rdy=%b expected %b", k, wr_rdy, rdy_exp[k]);
            end
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (wr_rdy !== 1'b0) begin n_err++; $display("FAIL tx_full hold: wr_rdy=%b expected 0", wr_rdy); end
        for (int k = 0; k < 5; k++) read_byte(vals[k], "tx_full");
        idle(80);
        check_rd_rdy(1'b0, "tx_full 6th dropped");
        loop_en = 1'b0;
    endtask

    task automatic test_rx_overrun();
        logic [7:0] vals [5];
        vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        for (int k = 0; k < 5; k++) send_frame(vals[k], 1'b0, 1'b0);
        check_flags(1'b0, 1'b0, 1'b1, "overrun set");
        for (int k = 0; k < 4; k++) read_byte(vals[k], "overrun data");
        check_rd_rdy(1'b0, "overrun 5th dropped");
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check_flags(1'b0, 1'b0, 1'b0, "overrun clear");
    endtask

    task automatic test_parity_err();
        send_frame(8'h5A, 1'b1, 1'b0);
        check_flags(1'b1, 1'b0, 1'b0, "parity set");
        read_byte(8'h5A, "parity stored");
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check_flags(1'b0, 1'b0, 1'b0, "parity clear");
    endtask

    task automatic test_glitch();
        @(posedge clk); #1;
        rx_drv = 1'b0;
        @(posedge clk); #1;
        rx_drv = 1'b1;
        idle(20);
        check_rd_rdy(1'b0, "glitch");
        check_flags(1'b0, 1'b0, 1'b0, "glitch");
    endtask

    task automatic test_frame_err();
        send_frame(8'h77, 1'b0, 1'b1);
        check_flags(1'b0, 1'b1, 1'b0, "frame set");
        check_rd_rdy(1'b0, "frame discarded");
    endtask

    task automatic test_reset_mid();
        send_frame(8'h42, 1'b0, 1'b0);
        check_rd_rdy(1'b1, "pre-reset rx byte");
        push_one(8'hC3);
        // 14 more edges puts the line in data bit 2, which is 0 for 0xC3
        idle(14);
        @(negedge clk);
        n_vec++;
        if (tx !== 1'b0) begin n_err++; $display("FAIL reset_mid pre: tx=%b expected 0", tx); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({tx, wr_rdy, rd_rdy, dout} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_mid outputs tx/wr_rdy/rd_rdy/dout: got %b%b%b/%h expected 110/00",
                     tx, wr_rdy, rd_rdy, dout);
        end
        check_flags(1'b0, 1'b0, 1'b0, "reset_mid");
        push_one(8'h3C);
        check_frame(8'h3C, "after_reset");
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_tx_full();
        test_rx_overrun();
        test_parity_err();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
